maxnet_datapath: RTL and testbench

- Four-node winner-take-all (MAXNET) engine selecting the largest of four 5-bit unsigned inputs.
- Each iteration, every processing element subtracts a fraction of its three peers' activations and clamps at zero, until at most one node stays nonzero.
- Outputs the index of the winner and its original input value.
- Sits between an operand source with a start/done handshake and downstream logic that consumes result/idx.

---
 rtl/maxnet_pkg.sv | 38 +++
 rtl/maxnet_pe.sv | 30 +++
 rtl/maxnet_datapath.sv | 174 +++++++++++++++++
 tb/tb_maxnet_datapath.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// maxnet_pkg: shared widths, FSM state encoding and node-index type for the
// four-node MAXNET winner-take-all engine.
//   DATA_W    : operand / result width
//   FRAC_W    : fractional bits appended to each activation
//   ACT_W     : activation register width (DATA_W + FRAC_W)
//   EPS_SHIFT : inhibition weight eps = 2^-EPS_SHIFT (must keep eps < 1/3)
//   SUM_W     : width of the three-peer sum (ACT_W + 2, cannot overflow)
package maxnet_pkg;

    localparam int unsigned DATA_W    = 5;
    localparam int unsigned FRAC_W    = 4;
    localparam int unsigned ACT_W     = DATA_W + FRAC_W;
    localparam int unsigned EPS_SHIFT = 2;
    localparam int unsigned SUM_W     = ACT_W + 2;
    localparam int unsigned N_NODES   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [1:0]        node_idx_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ACT_W-1:0]  act_t;
    typedef logic [SUM_W-1:0]  sum_t;

    // Lowest set bit position of a per-node flag vector; 0 when no bit is set.
    function automatic node_idx_t lowest_set(input logic [N_NODES-1:0] m);
        node_idx_t r;
        r = '0;
        for (int i = N_NODES - 1; i >= 0; i--) begin
            if (m[i]) r = node_idx_t'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/maxnet_pe.sv
// maxnet_pe: one MAXNET processing element (purely combinational).
// Subtracts ceil(sum_of_peers / 2^EPS_SHIFT) from its own activation and
// clamps the result at zero.
//   self_i   : this node's current activation
//   peer_*_i : the other three nodes' current activations
//   next_o   : activation for the next iteration
module maxnet_pe
    import maxnet_pkg::*;
(
    input  act_t self_i,
    input  act_t peer_a_i,
    input  act_t peer_b_i,
    input  act_t peer_c_i,
    output act_t next_o
);

    sum_t sum_w;
    sum_t pen_w;
    sum_t self_w;
    logic frac_nz_w;

    assign sum_w     = sum_t'(peer_a_i) + sum_t'(peer_b_i) + sum_t'(peer_c_i);
    // Rounding the penalty up guarantees every nonzero node with a nonzero
    // peer loses at least one LSB per iteration, so the network always settles.
    assign frac_nz_w = |sum_w[EPS_SHIFT-1:0];
    assign pen_w     = (sum_w >> EPS_SHIFT) + sum_t'(frac_nz_w);
    assign self_w    = sum_t'(self_i);
    assign next_o    = (self_w > pen_w) ? act_t'(self_w - pen_w) : '0;

endmodule

// File: rtl/maxnet_datapath.sv
// maxnet_datapath: four-node MAXNET engine returning the index and original
// value of the largest of four unsigned operands.
// Handshake: start is sampled only in IDLE or DONE; operands are captured on
// that edge, busy is high while iterating, done is high (with result/idx
// stable) from the finishing edge until the next accepted start or reset.
// Ties decay to zero together and resolve to the lowest index.
// Ports:
//   clk, rst (sync, active-low), start, x1..x4 (operands)
//   result (winning operand), idx (winner 0..3), done, busy
//   timeout (only with MAXNET_ITER_LIMIT_EN), dbg_state_o (FSM state)
// Optional build macro MAXNET_ITER_LIMIT_EN adds ITER_MAX and timeout: the
// run is forced to DONE after ITER_MAX iterations without settling.
module maxnet_datapath
    import maxnet_pkg::*;
`ifdef MAXNET_ITER_LIMIT_EN
#(
    parameter int unsigned ITER_MAX = 63
)
`endif
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] x2,
    input  logic [DATA_W-1:0] x3,
    input  logic [DATA_W-1:0] x4,
    output logic [DATA_W-1:0] result,
    output logic [1:0]        idx,
    output logic              done,
    output logic              busy,
`ifdef MAXNET_ITER_LIMIT_EN
    output logic              timeout,
`endif
    output state_e            dbg_state_o
);

    state_e    state_q, state_d;
    act_t      a_q[N_NODES];
    act_t      a_d[N_NODES];
    act_t      n_w[N_NODES];
    data_t     op_q[N_NODES];
    data_t     op_d[N_NODES];
    data_t     x_w[N_NODES];
    data_t     result_q, result_d;
    node_idx_t idx_q, idx_d;

    logic [N_NODES-1:0] n_nz_w;
    logic [N_NODES-1:0] a_nz_w;
    logic               finish_w;
    node_idx_t          winner_w;
    node_idx_t          fallback_w;

`ifdef MAXNET_ITER_LIMIT_EN
    localparam int unsigned CNT_W = 6;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             limit_hit_w;
    // cnt_q holds the number of completed iterations before this cycle.
    assign limit_hit_w = (cnt_q == CNT_W'(ITER_MAX - 1));
`endif

    assign x_w[0] = x1;
    assign x_w[1] = x2;
    assign x_w[2] = x3;
    assign x_w[3] = x4;

    for (genvar g = 0; g < N_NODES; g++) begin : g_pe
        maxnet_pe u_pe (
            .self_i   (a_q[g]),
            .peer_a_i (a_q[(g + 1) % N_NODES]),
            .peer_b_i (a_q[(g + 2) % N_NODES]),
            .peer_c_i (a_q[(g + 3) % N_NODES]),
            .next_o   (n_w[g])
        );
    end

    // Winner decode on the next-iteration activations.
    always_comb begin
        for (int i = 0; i < N_NODES; i++) begin
            n_nz_w[i] = (n_w[i] != '0);
            a_nz_w[i] = (a_q[i] != '0);
        end
    end

    // At most one bit set <=> clearing the lowest set bit leaves zero.
    assign finish_w   = ((n_nz_w & (n_nz_w - {{(N_NODES-1){1'b0}}, 1'b1})) == '0);
    // When everything collapsed at once, the nodes alive just before are tied.
    assign fallback_w = lowest_set(a_nz_w);
    assign winner_w   = (n_nz_w != '0) ? lowest_set(n_nz_w) : fallback_w;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            idx_q    <= '0;
            for (int i = 0; i < N_NODES; i++) begin
                a_q[i]  <= '0;
                op_q[i] <= '0;
            end
`ifdef MAXNET_ITER_LIMIT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            op_q     <= op_d;
`ifdef MAXNET_ITER_LIMIT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        op_d     = op_q;
        result_d = result_q;
        idx_d    = idx_q;
`ifdef MAXNET_ITER_LIMIT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    for (int i = 0; i < N_NODES; i++) begin
                        op_d[i] = x_w[i];
                        a_d[i]  = {x_w[i], {FRAC_W{1'b0}}};
                    end
                    state_d = ITER;
`ifdef MAXNET_ITER_LIMIT_EN
                    cnt_d     = '0;
                    timeout_d = 1'b0;
`endif
                end
            end
            ITER: begin
                a_d = n_w;
`ifdef MAXNET_ITER_LIMIT_EN
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
`endif
                if (finish_w) begin
                    idx_d    = winner_w;
                    result_d = op_q[winner_w];
                    state_d  = DONE;
                end
`ifdef MAXNET_ITER_LIMIT_EN
                else if (limit_hit_w) begin
                    idx_d     = fallback_w;
                    result_d  = op_q[fallback_w];
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign result      = result_q;
    assign idx         = idx_q;
    assign done        = (state_q == DONE);
    assign busy        = (state_q == ITER);
    assign dbg_state_o = state_q;
`ifdef MAXNET_ITER_LIMIT_EN
    assign timeout     = timeout_q;
`endif

endmodule

// File: tb/tb_maxnet_datapath.sv
module tb_maxnet_datapath;
  import maxnet_pkg::*;

  typedef struct {
    logic [DATA_W-1:0] x1, x2, x3, x4;
    logic [1:0]        e_idx;
    logic [DATA_W-1:0] e_res;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] x1, x2, x3, x4;
  logic [DATA_W-1:0] result;
  logic [1:0]        idx;
  logic              done;
  logic              busy;
  state_e            dbg_state;
`ifdef MAXNET_ITER_LIMIT_EN
  logic              timeout;
`endif

  int n_vec = 0;
  int n_bad = 0;
  logic [6:0] exp_q[$];

  maxnet_datapath dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .x1          (x1),
    .x2          (x2),
    .x3          (x3),
    .x4          (x4),
    .result      (result),
    .idx         (idx),
    .done        (done),
    .busy        (busy),
`ifdef MAXNET_ITER_LIMIT_EN
    .timeout     (timeout),
`endif
    .dbg_state_o (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: iterate the inhibition rule on integer activations until at
  // most one node survives; reports winner, its operand, iteration count.
  function automatic void model(input int xv[4], output int e_idx,
                                output int e_res, output int e_it);
    int a[4];
    int n[4];
    int s, pen, cnt, div;
    bit found;
    div = 1 << EPS_SHIFT;
    for (int i = 0; i < 4; i++) a[i] = xv[i] * (1 << FRAC_W);
    e_it = 0;
    cnt = 0;
    for (int it = 0; it < 500; it++) begin
      e_it++;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
        s = 0;
        for (int j = 0; j < 4; j++) if (j != i) s += a[j];
        pen = (s + div - 1) / div;
        n[i] = (a[i] > pen) ? a[i] - pen : 0;
        if (n[i] > 0) cnt++;
      end
      if (cnt <= 1) break;
      a = n;
    end
    e_idx = 0;
    found = 0;
    if (cnt == 1) begin
      for (int i = 0; i < 4; i++) if (n[i] > 0) e_idx = i;
    end else begin
      for (int i = 0; i < 4; i++) if (!found && a[i] > 0) begin
        e_idx = i;
        found = 1;
      end
    end
    e_res = xv[e_idx];
  endfunction

  function automatic vec_t mk(input int a, input int b, input int c,
                              input int d, input int i, input int r);
    vec_t v;
    v.x1 = DATA_W'(a); v.x2 = DATA_W'(b); v.x3 = DATA_W'(c); v.x4 = DATA_W'(d);
    v.e_idx = 2'(i);
    v.e_res = DATA_W'(r);
    return v;
  endfunction

  // Driver: present operands with start for one edge; returns at the
  // negedge just after the start edge.
  task automatic launch(input int a, input int b, input int c, input int d);
    @(negedge clk);
    x1 = DATA_W'(a); x2 = DATA_W'(b); x3 = DATA_W'(c); x4 = DATA_W'(d);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts rising edges until done is seen (bounded).
  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < 400) begin
      @(negedge clk);
      edges++;
    end
    check("done seen", done, 1);
  endtask

  task automatic run_check(input string name, input int a, input int b,
                           input int c, input int d);
    int xv[4];
    int ei, er, eit, edges;
    logic [6:0] e;
    xv = '{a, b, c, d};
    model(xv, ei, er, eit);
    exp_q.push_back({2'(ei), DATA_W'(er)});
    launch(a, b, c, d);
    wait_done(edges);
    e = exp_q.pop_front();
    check({name, " idx"}, idx, e[6:5]);
    check({name, " result"}, result, e[4:0]);
    check({name, " latency"}, edges, eit);
    check({name, " busy"}, busy, 0);
  endtask

  initial begin
    vec_t tbl[8];
    int edges;
    int a, b, c, d;

    rst = 1'b0; start = 1'b0;
    x1 = '0; x2 = '0; x3 = '0; x4 = '0;
    repeat (3) @(negedge clk);
    check("reset result", result, 0);
    check("reset idx", idx, 0);
    check("reset done", done, 0);
    check("reset busy", busy, 0);
    check("reset state", dbg_state, IDLE);
    rst = 1'b1;
    @(negedge clk);

    tbl[0] = mk( 3, 17,  9, 30, 3, 30);
    tbl[1] = mk(12, 12,  4,  0, 0, 12);
    tbl[2] = mk( 0,  0,  0,  0, 0,  0);
    tbl[3] = mk( 1,  2,  3,  4, 3,  4);
    tbl[4] = mk(31, 31, 31, 31, 0, 31);
    tbl[5] = mk( 5,  0,  0,  0, 0,  5);
    tbl[6] = mk( 0,  0,  0,  9, 3,  9);
    tbl[7] = mk( 7, 29, 29,  2, 1, 29);
    for (int i = 0; i < 8; i++) begin
      run_check($sformatf("tbl%0d", i), tbl[i].x1, tbl[i].x2, tbl[i].x3, tbl[i].x4);
      check($sformatf("tbl%0d table idx", i), idx, tbl[i].e_idx);
      check($sformatf("tbl%0d table result", i), result, tbl[i].e_res);
    end

    // Single nonzero operand settles in one iteration: done on the first
    // edge after the start edge.
    launch(0, 0, 7, 0);
    check("single busy", busy, 1);
    check("single early done", done, 0);
    @(negedge clk);
    check("single done", done, 1);
    check("single idx", idx, 2);
    check("single result", result, 7);

    // Reset in the second ITER cycle of a long run aborts it.
    launch(12, 12, 4, 0);
    check("abort busy1", busy, 1);
    @(negedge clk);
    check("abort busy2", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort result", result, 0);
    check("abort idx", idx, 0);
    rst = 1'b1;
    run_check("rerun", 20, 5, 3, 1);
    check("rerun table idx", idx, 0);
    check("rerun table result", result, 20);

    // start while busy is ignored.
    launch(3, 17, 9, 30);
    x1 = 5'd31; x2 = '0; x3 = '0; x4 = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(edges);
    check("ignore idx", idx, 3);
    check("ignore result", result, 30);
    check("ignore latency", edges + 1, 3);
    run_check("from done", 1, 2, 3, 4);
    check("from done table idx", idx, 3);
    check("from done table result", result, 4);

    // Randomized operands, with forced ties part of the time.
    for (int k = 0; k < 40; k++) begin
      a = $urandom_range(0, 31);
      b = $urandom_range(0, 31);
      c = $urandom_range(0, 31);
      d = $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) c = a;
      if ($urandom_range(0, 5) == 0) d = b;
      run_check($sformatf("rand%0d", k), a, b, c, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
